// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: default port addresses,
// status-word bit positions and field widths, and the status packing helper.
package mmio_port_responder_pkg;

  localparam int unsigned DEF_DATA_ADDR   = 96;
  localparam int unsigned DEF_STAT_ADDR   = 97;

  localparam int unsigned ST_RX_NOT_EMPTY = 0;
  localparam int unsigned ST_TX_NOT_FULL  = 1;
  localparam int unsigned ST_RX_UNDERRUN  = 2;
  localparam int unsigned ST_TX_DROP      = 3;
  localparam int unsigned ST_RX_COUNT_LSB = 4;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W      = 4;
  localparam int unsigned ST_W            = 12;

  function automatic logic [ST_W-1:0] pack_status(
    input logic [ST_COUNT_W-1:0] tx_cnt,
    input logic [ST_COUNT_W-1:0] rx_cnt,
    input logic                  tx_drop,
    input logic                  rx_under,
    input logic                  tx_not_full,
    input logic                  rx_not_empty
  );
    logic [ST_W-1:0] s;
    s = {ST_W{1'b0}};
    s[ST_TX_COUNT_LSB +: ST_COUNT_W] = tx_cnt;
    s[ST_RX_COUNT_LSB +: ST_COUNT_W] = rx_cnt;
    s[ST_TX_DROP]                    = tx_drop;
    s[ST_RX_UNDERRUN]                = rx_under;
    s[ST_TX_NOT_FULL]                = tx_not_full;
    s[ST_RX_NOT_EMPTY]               = rx_not_empty;
    return s;
  endfunction

endpackage

// File: rtl/mmio_port_responder_port_fifo.sv
// Small synchronous FIFO used for both the TX and RX directions.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module port_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage array; contents are only ever observed through the count-gated head.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// CPU-side MMIO responder: data port queues stores to TX and drains RX on loads,
// status port reports FIFO levels and sticky drop/underrun flags.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter int unsigned WIDTH     = 17,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_ADDR = DEF_DATA_ADDR,
  parameter int unsigned STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_address,
  input  logic [WIDTH-1:0] i_write_data,
  input  logic             i_write_enable,
  input  logic             i_read_enable,
  output logic [WIDTH-1:0] o_read_data,
  output logic [WIDTH-1:0] o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  input  logic [WIDTH-1:0] i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             w_hit_data;
  logic             w_hit_stat;
  logic             w_tx_store;
  logic             w_tx_pop;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic [CW-1:0]    w_tx_count;
  logic             w_rx_load;
  logic             w_rx_push;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [CW-1:0]    w_rx_count;
  logic [WIDTH-1:0] w_rx_head;
  logic             w_stat_load;
  logic             w_drop_evt;
  logic             w_under_evt;
  logic [ST_W-1:0]  w_status;
  logic             r_tx_drop;
  logic             r_rx_under;

  assign w_hit_data  = (i_address == WIDTH'(DATA_ADDR));
  assign w_hit_stat  = (i_address == WIDTH'(STAT_ADDR));
  assign w_tx_store  = i_write_enable && w_hit_data;
  assign w_rx_load   = i_read_enable && w_hit_data;
  assign w_stat_load = i_read_enable && w_hit_stat;

  // Handshake outputs depend only on registered occupancy, never on the peer's input.
  assign o_tx_valid  = !w_tx_empty;
  assign o_rx_ready  = !w_rx_full;
  assign w_tx_pop    = o_tx_valid && i_tx_ready;
  assign w_rx_push   = i_rx_valid && o_rx_ready;
  assign w_drop_evt  = w_tx_store && w_tx_full && !w_tx_pop;
  assign w_under_evt = w_rx_load && w_rx_empty;

  assign w_status = pack_status(ST_COUNT_W'(w_tx_count), ST_COUNT_W'(w_rx_count),
                                r_tx_drop, r_rx_under, !w_tx_full, !w_rx_empty);

  port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_push  (w_tx_store),
    .i_wdata (i_write_data),
    .i_pop   (w_tx_pop),
    .o_head  (o_tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_push  (w_rx_push),
    .i_wdata (i_rx_data),
    .i_pop   (w_rx_load),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // Sticky flags: a status load clears them unless a new event lands on the same edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_drop  <= 1'b0;
      r_rx_under <= 1'b0;
    end else begin
      r_tx_drop  <= w_drop_evt  || (r_tx_drop  && !w_stat_load);
      r_rx_under <= w_under_evt || (r_rx_under && !w_stat_load);
    end
  end

  // Load result mux, valid in the strobe cycle.
  always_comb begin
    o_read_data = {WIDTH{1'b0}};
    if (w_rx_load) begin
      o_read_data = w_rx_head;
    end else if (w_stat_load) begin
      o_read_data = WIDTH'(w_status);
    end else begin
      o_read_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Randomized bench for mmio_port_responder against a queue-based reference model.
module tb_mmio_port_responder;

  localparam int W = 17;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] addr, wdata, rdata, tx_data, rx_data;
  logic         we, re, tx_valid, tx_ready, rx_valid, rx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  bit           m_drop;
  bit           m_under;

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_address      (addr),
    .i_write_data   (wdata),
    .i_write_enable (we),
    .i_read_enable  (re),
    .o_read_data    (rdata),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int tc = tx_q.size();
    int rc = rx_q.size();
    return (tc << 8) | (rc << 4) | (int'(m_drop) << 3) | (int'(m_under) << 2)
         | (int'(tc < D) << 1) | int'(rc > 0);
  endfunction

  function automatic logic [31:0] model_rdata();
    if (re && addr == 96) return (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0;
    if (re && addr == 97) return model_status();
    return 32'd0;
  endfunction

  // One clock cycle: drive after the falling edge, check, then advance the model on the rising edge.
  task automatic step(input int a, input logic [W-1:0] wd, input bit w, input bit r,
                      input bit txr, input logic [W-1:0] rxd, input bit rxv);
    bit tx_pop, rx_push, dl, sl, st, ev_d, ev_u;
    addr = W'(a); wdata = wd; we = w; re = r;
    tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    #1;
    check_eq("read_data", 32'(rdata), model_rdata());
    check_eq("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
    check_eq("tx_data", 32'(tx_data), (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'd0);
    check_eq("rx_ready", 32'(rx_ready), 32'(rx_q.size() < D));
    @(posedge clk);
    tx_pop  = (tx_q.size() > 0) && txr;
    rx_push = rxv && (rx_q.size() < D);
    dl = r && (a == 96);
    sl = r && (a == 97);
    st = w && (a == 96);
    ev_d = 1'b0;
    ev_u = 1'b0;
    if (dl) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      else ev_u = 1'b1;
    end
    if (tx_pop) void'(tx_q.pop_front());
    if (st) begin
      if (tx_q.size() < D) tx_q.push_back(wd);
      else ev_d = 1'b1;
    end
    if (rx_push) rx_q.push_back(rxd);
    m_drop  = ev_d || (m_drop && !sl);
    m_under = ev_u || (m_under && !sl);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, txr, '0, 0);
  endtask

  task automatic apply_reset();
    addr = '0; wdata = '0; we = 0; re = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("rst_read_data", 32'(rdata), 32'd0);
    tx_q.delete();
    rx_q.delete();
    m_drop = 1'b0;
    m_under = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    step(97, '0, 0, 1, 0, '0, 0);
    check_eq("rst_status_const", 32'(rdata), 32'h2);

    // TX ordering with back-pressure.
    step(96, 17'd5, 1, 0, 0, '0, 0);
    step(96, 17'd6, 1, 0, 0, '0, 0);
    step(96, 17'd7, 1, 0, 0, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);
    idle(4, 1);

    // TX overflow and sticky clear.
    for (int i = 0; i < 4; i++) step(96, W'(20 + i), 1, 0, 0, '0, 0);
    step(96, 17'd9, 1, 0, 0, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);
    // Full TX with store and pop on the same edge.
    step(96, 17'd11, 1, 0, 1, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);
    idle(5, 1);

    // RX ordering and underrun.
    step(0, '0, 0, 0, 0, 17'h1ABCD, 1);
    step(0, '0, 0, 0, 0, 17'h00010, 1);
    step(96, '0, 0, 1, 0, '0, 0);
    step(96, '0, 0, 1, 0, '0, 0);
    step(96, '0, 0, 1, 0, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);

    // Full RX with a held producer word.
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 0, W'(17'h100 + i), 1);
    step(96, '0, 0, 1, 0, 17'h1F0F0, 1);
    step(0, '0, 0, 0, 0, 17'h1F0F0, 1);
    for (int i = 0; i < 5; i++) step(96, '0, 0, 1, 0, '0, 0);

    // Non-hit addresses, store to status, and store+load together.
    step(95, 17'd33, 1, 0, 0, '0, 0);
    step(98, '0, 0, 1, 0, '0, 0);
    step(97, 17'd44, 1, 0, 0, '0, 0);
    step(96, 17'd55, 1, 1, 0, '0, 0);
    step(97, '0, 0, 1, 0, '0, 0);

    // Reset with words in flight.
    step(96, 17'd66, 1, 0, 0, 17'd77, 1);
    apply_reset();
    step(97, '0, 0, 1, 0, '0, 0);
    check_eq("post_rst_status", 32'(rdata), 32'h2);

    // Random traffic focused on the two hit addresses.
    for (int i = 0; i < 1500; i++) begin
      int a;
      case ($urandom_range(0, 9))
        0:       a = 95;
        1:       a = 98;
        2, 3:    a = 97;
        default: a = 96;
      endcase
      step(a, W'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
